// File: rtl/decumulator_pkg.sv
// rtl/decumulator_pkg.sv - shared state encoding, digit patterns and defaults for decumulator
package decumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_UFLOW = 2'd2
  } state_e;

  localparam int CNT_DEFAULT = 100000000;

  // Active-low segment patterns {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] dec_tens(input logic [4:0] v);
    dec_tens = 4'(v / 5'd10);
  endfunction

  function automatic logic [3:0] dec_units(input logic [4:0] v);
    dec_units = 4'(v % 5'd10);
  endfunction

endpackage

// File: rtl/decumulator_if.sv
// rtl/decumulator_if.sv - switch/key inputs and LED/display outputs of decumulator
interface decumulator_if;
  logic [3:0] B;
  logic       LOAD_N;
  logic       START_N;
  logic [3:0] LEDB;
  logic       LEDC;
  logic       LEDU;
  logic [6:0] HEXB1;
  logic [6:0] HEXB0;
  logic [6:0] HEXA1;
  logic [6:0] HEXA0;

  modport master (
    output B, LOAD_N, START_N,
    input  LEDB, LEDC, LEDU, HEXB1, HEXB0, HEXA1, HEXA0
  );

  modport slave (
    input  B, LOAD_N, START_N,
    output LEDB, LEDC, LEDU, HEXB1, HEXB0, HEXA1, HEXA0
  );
endinterface

// File: rtl/dec_7seg.sv
// rtl/dec_7seg.sv - one decimal digit to active-low 7-segment pattern
module dec_7seg
  import decumulator_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7(digit_i);

endmodule

// File: rtl/decumulator_key_edge.sv
// rtl/decumulator_key_edge.sv - 2-flop key synchroniser with one-cycle falling-edge pulse
module decumulator_key_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic key_n_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  // [1:0] synchronise, [2] remembers the previous synchronised level.
  always_ff @(posedge CLK) begin
    if (!RST_N) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], key_n_i};
  end

  assign pulse_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/decumulator.sv
// rtl/decumulator.sv - periodic saturating down-counter with key control and 7-segment display
module decumulator
  import decumulator_pkg::*;
#(
  parameter int CNT      = CNT_DEFAULT,
  parameter int INIT_VAL = 30
) (
  input  logic          CLK,
  input  logic          RST_N,
  decumulator_if.slave  io
);

  localparam int            CW       = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT - 1);
  localparam logic [4:0]    A_INIT   = 5'(INIT_VAL);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ledc_q, ledc_d;
  logic          ledu_q, ledu_d;
  logic [4:0]    a_q, a_d;
  logic          load_p, start_p;
  logic [4:0]    b_ext;
  logic          b_ge10;
  logic [3:0]    b_tens, b_units, a_tens, a_units;

  decumulator_key_edge u_key_load (
    .CLK(CLK), .RST_N(RST_N), .key_n_i(io.LOAD_N), .pulse_o(load_p)
  );

  decumulator_key_edge u_key_start (
    .CLK(CLK), .RST_N(RST_N), .key_n_i(io.START_N), .pulse_o(start_p)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ledc_q  <= 1'b0;
      ledu_q  <= 1'b0;
      a_q     <= A_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ledc_q  <= ledc_d;
      ledu_q  <= ledu_d;
      a_q     <= a_d;
    end
  end

  assign b_ext = {1'b0, io.B};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ledc_d  = ledc_q;
    ledu_d  = ledu_q;
    a_d     = a_q;
    if (load_p) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ledc_d  = 1'b0;
      ledu_d  = 1'b0;
      a_d     = A_INIT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (start_p) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            ledc_d = ~ledc_q;
            // Only the rising half of LEDC carries a subtract step.
            if (!ledc_q) begin
              if (b_ext <= a_q) begin
                a_d = a_q - b_ext;
              end else begin
                a_d     = '0;
                ledu_d  = 1'b1;
                state_d = ST_UFLOW;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_UFLOW: begin
          cnt_d = '0;
          a_d   = '0;
        end
        default: begin
          cnt_d = '0;
          if (start_p) begin
            state_d = ST_RUN;
            ledc_d  = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    io.LEDB = io.B;
    io.LEDC = ledc_q;
    io.LEDU = ledu_q;
    b_ge10  = (io.B >= 4'd10);
    b_tens  = {3'b000, b_ge10};
    b_units = b_ge10 ? (io.B - 4'd10) : io.B;
    a_tens  = dec_tens(a_q);
    a_units = dec_units(a_q);
  end

  dec_7seg u_hex_b1 (.digit_i(b_tens),  .seg_o(io.HEXB1));
  dec_7seg u_hex_b0 (.digit_i(b_units), .seg_o(io.HEXB0));
  dec_7seg u_hex_a1 (.digit_i(a_tens),  .seg_o(io.HEXA1));
  dec_7seg u_hex_a0 (.digit_i(a_units), .seg_o(io.HEXA0));

endmodule

// File: tb/tb_decumulator.sv
// tb/tb_decumulator.sv - randomized self-checking bench for decumulator against a timeline model
module tb_decumulator;

  localparam int CNT  = 4;
  localparam int INIT = 30;

  logic clk;
  logic rst_n;

  decumulator_if bus ();

  decumulator #(.CNT(CNT), .INIT_VAL(INIT)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0=idle 1=run 2=uflow; run_t counts cycles since entering RUN.
  int  m_a, m_mode, run_t;
  bit  m_ledc, m_ledu;
  int  edge_n;
  int  ld_at, st_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  task automatic model_edge();
    bit ld, st;
    if (!rst_n) begin
      m_a = INIT; m_mode = 0; run_t = 0; m_ledc = 0; m_ledu = 0;
      ld_at = -1; st_at = -1;
      return;
    end
    ld = (ld_at == edge_n);
    st = (st_at == edge_n);
    if (ld) begin
      m_a = INIT; m_mode = 0; m_ledc = 0; m_ledu = 0;
    end else if (m_mode == 0) begin
      if (st) begin m_mode = 1; run_t = 0; m_ledc = 0; end
    end else if (m_mode == 1) begin
      if (st) begin
        m_mode = 0;
      end else begin
        run_t++;
        if (run_t % CNT == 0) m_ledc = !m_ledc;
        if (run_t % (2 * CNT) == CNT) begin
          if (int'(bus.B) > m_a) begin m_a = 0; m_ledu = 1; m_mode = 2; end
          else m_a = m_a - int'(bus.B);
        end
      end
    end
  endtask

  task automatic compare_all();
    int b;
    b = int'(bus.B);
    check("ledb", {28'd0, bus.LEDB}, b);
    check("hexb", {18'd0, bus.HEXB1, bus.HEXB0}, {18'd0, seg_of(b / 10), seg_of(b % 10)});
    check("hexa", {18'd0, bus.HEXA1, bus.HEXA0}, {18'd0, seg_of(m_a / 10), seg_of(m_a % 10)});
    check("ledc", {31'd0, bus.LEDC}, {31'd0, m_ledc});
    check("ledu", {31'd0, bus.LEDU}, {31'd0, m_ledu});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  // Key goes low now (after edge edge_n); the command lands on the 3rd edge.
  task automatic press(input bit ld, input bit st, input int hold);
    if (ld) begin bus.LOAD_N = 1'b0; ld_at = edge_n + 3; end
    if (st) begin bus.START_N = 1'b0; st_at = edge_n + 3; end
    cycles(hold);
    bus.LOAD_N  = 1'b1;
    bus.START_N = 1'b1;
    cycles(4);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
  endtask

  initial begin
    edge_n = 0; ld_at = -1; st_at = -1;
    m_a = INIT; m_mode = 0; run_t = 0; m_ledc = 0; m_ledu = 0;
    rst_n = 1'b0; bus.B = 4'd7; bus.LOAD_N = 1'b1; bus.START_N = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(50);

    // 30 -> 23 -> 16 -> 9 -> 2 -> underflow, then START ignored in UFLOW
    press(0, 1, 20);
    cycles(50);
    press(0, 1, 2);
    cycles(12);

    press(1, 0, 3);
    bus.B = 4'd15;
    press(0, 1, 1);
    cycles(40);

    press(1, 0, 2);
    bus.B = 4'd0;
    press(0, 1, 2);
    cycles(45);
    press(0, 1, 1);
    cycles(10);
    press(0, 1, 1);
    cycles(20);

    press(1, 1, 2);
    cycles(10);
    bus.B = 4'd3;
    press(0, 1, 2);
    cycles(5);
    pulse_reset();
    cycles(20);

    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    begin bus.B = 4'($urandom_range(0, 15)); cycles(1); end
        2, 3, 4: press(0, 1, $urandom_range(1, 6));
        5:       press(1, 0, $urandom_range(1, 6));
        6:       press(1, 1, $urandom_range(1, 3));
        7:       pulse_reset();
        default: cycles($urandom_range(1, 12));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
